// File: rtl/block_mac_2x2.sv
// rtl/block_mac_2x2.sv - 2x2 block matrix multiply-accumulate on one time-shared multiplier
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   in_valid / in_ready  operand tile handshake (ready only while idle)
//   a00..a11, b00..b11   operand tiles, element (row, column)
//   in_first             tile starts a new result block (clear accumulators)
//   in_last              tile ends the result block (present result afterwards)
//   out_valid/out_ready  result handshake (valid only while holding a result)
//   c00..c11             registered accumulator values
`timescale 1ns/1ps

module block_mac_2x2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a00,
    input  logic [DATA_WIDTH-1:0] a01,
    input  logic [DATA_WIDTH-1:0] a10,
    input  logic [DATA_WIDTH-1:0] a11,
    input  logic [DATA_WIDTH-1:0] b00,
    input  logic [DATA_WIDTH-1:0] b01,
    input  logic [DATA_WIDTH-1:0] b10,
    input  logic [DATA_WIDTH-1:0] b11,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] c00,
    output logic [DATA_WIDTH-1:0] c01,
    output logic [DATA_WIDTH-1:0] c10,
    output logic [DATA_WIDTH-1:0] c11
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured operands and accumulators, indexed {row, column}.
    logic [DATA_WIDTH-1:0] a_q   [4];
    logic [DATA_WIDTH-1:0] b_q   [4];
    logic [DATA_WIDTH-1:0] acc   [4];
    logic [2:0]            step;
    logic                  last_q;

    logic                  accept;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [DATA_WIDTH-1:0] prod;
    logic [1:0]            acc_idx;

    assign accept = in_valid && in_ready;

    // Step k computes c[i][j] += a[i][m] * b[m][j] with i = k[2], j = k[1], m = k[0].
    // So the target accumulator is {k[2], k[1]}, A is read at {k[2], k[0]} and B at {k[0], k[1]}.
    assign acc_idx = step[2:1];
    assign mul_a   = a_q[{step[2], step[0]}];
    assign mul_b   = b_q[{step[0], step[1]}];

    // The single shared multiplier; only the low DATA_WIDTH bits of the product are kept,
    // which are identical for signed and unsigned operands.
    assign prod = mul_a * mul_b;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                if (step == 3'd7) begin
                    state_next = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture and accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                acc[i] <= '0;
            end
            step   <= 3'd0;
            last_q <= 1'b0;
        end else if (accept) begin
            a_q[0] <= a00;
            a_q[1] <= a01;
            a_q[2] <= a10;
            a_q[3] <= a11;
            b_q[0] <= b00;
            b_q[1] <= b01;
            b_q[2] <= b10;
            b_q[3] <= b11;
            last_q <= in_last;
            step   <= 3'd0;
            if (in_first) begin
                for (int i = 0; i < 4; i++) begin
                    acc[i] <= '0;
                end
            end
        end else if (state == MUL) begin
            acc[acc_idx] <= acc[acc_idx] + prod;
            // Wraps back to 0 after step 7, ready for the next tile.
            step         <= step + 3'd1;
        end
    end

    assign c00 = acc[0];
    assign c01 = acc[1];
    assign c10 = acc[2];
    assign c11 = acc[3];

endmodule
